kws_wsram_arbiter: RTL and testbench
====================================

// Module: kws_wsram_arbiter
// PURPOSE
//  Shares the single-port 1Kx32 weight SRAM between two masters: M0 is the
//  dilated-CNN weight fetch port, and M1 is the host/preload port used for weight
//  writes and debug reads.
//  Round-robin arbitration with burst ownership. MAX_BURST caps ownership so the
//  other master cannot starve.
//  Sits between the CNN core, the host bridge and the weight SRAM macro.
// PARAMETERS
//  AW         10  SRAM address width (words)
//  DW         32  SRAM data width
//  MAX_BURST  64  max consecutive beats per ownership when the other master waits
// PORTS
//  clk           in   1   clock
//  rst_n         in   1   async active-low reset
//  mX_req        in   1   X=0,1: master requests one beat; held high for bursts
//  mX_we         in   1   beat is a write (1) or read (0)
//  mX_addr       in   AW  beat address
//  mX_wdata      in   DW  write data
//  mX_gnt        out  1   beat accepted this cycle when mX_req&&mX_gnt
//  mX_rvalid     out  1   read data valid for master X
//  mX_rdata      out  DW  read data (= sram_rdata, gated by rvalid)
//  sram_en       out  1   SRAM access enable (registered)
//  sram_we       out  1   SRAM write enable (registered)
//  sram_addr     out  AW  SRAM address (registered)
//  sram_wdata    out  DW  SRAM write data (registered)
//  sram_rdata    in   DW  SRAM read data, valid 1 cycle after sram_en&&!sram_we
// BEHAVIOUR
//  Reset: all outputs 0; FSM=IDLE; last_owner=1 (M0 wins first tie); beat_cnt=0.
//  FSM states:
//  - IDLE: gnt to the sole requester.
//    - Both requesting: gnt to !last_owner.
//    - Enter OWNx on the accepted beat.
//  - OWNx: mX_gnt=1 combinationally while mX_req=1; beat_cnt++ per beat.
//    - mX_req=0: go to IDLE, set last_owner=X. That cycle grants nobody.
//    - beat_cnt==MAX_BURST-1 and other master requesting: that beat is accepted,
//      then go to OWN(other), beat_cnt=0, last_owner=X.
//    - Cap reached and other master idle: stay in OWNx, beat_cnt wraps to 0.
//  - gnt never asserted to both masters; gnt never asserted without req.
//  Latency: beat accepted in cycle N.
//  - SRAM controls are driven in N+1; sram_en=0 in cycles with no accepted beat.
//  - Reads: mX_rvalid=1 and mX_rdata valid in N+2.
//    A 1-deep tag pipeline routes each read to the master that issued it.
//  - Writes: no response.
//  - Back-to-back beats: 1 beat per cycle, including across an ownership switch.
//  Read data already in flight at an ownership switch still returns to the
//  original master.
//  mX_rdata is 0 when mX_rvalid is 0.
//  Req dropped mid-burst is legal. No beat is lost; beats in flight complete.
//  Reset mid-operation: in-flight reads are dropped (no rvalid) and all outputs
//  clear immediately.
// CONFIGURATION
//  KWS_ARB_STATS_EN defined: adds ports
//    stat_clr  in  1   sync clear of counters
//    stat_g0   out 16  accepted M0 beats
//    stat_g1   out 16  accepted M1 beats
//    stat_wait out 16  cycles where a req is high without a gnt
//  - Counters saturate at 16'hFFFF and reset to 0.
//  - stat_clr takes priority over increment in the same cycle.
//  Not defined: these ports and counters are absent; arbitration behaviour is
//  identical.
// TESTING
//  1. M0-only read burst, addr 0..239: gnt every cycle; rvalid N+2 with
//     rdata=mem[addr]; M1 never granted.
//  2. Both req asserted in the first cycle after reset: M0 granted first; after
//     64 beats M1 granted on the next cycle; no idle gap.
//  3. M1 writes 0xDEADBEEF to addr 0x3FF, then M0 reads 0x3FF: M0 rdata=0xDEADBEEF.
//  4. M0 read accepted on the last cycle before a switch to M1: m0_rvalid pulses
//     2 cycles later; m1_rvalid stays 0.
//  5. rst_n pulsed low with a read in flight: no rvalid; sram_en=0; FSM=IDLE;
//     next grant follows the reset tie-break (M0).
//  6. [KWS_ARB_STATS_EN] 100 M0 beats, 10 M1 beats under contention: stat_g0=100,
//     stat_g1=10; stat_wait=total cycles any req went ungranted; stat_clr -> all 0.

Source files
------------

// File: rtl/kws_wsram_arbiter_if.sv
// Per-master beat port of the weight SRAM arbiter: beat request in, grant and read response out.
interface kws_wsram_arbiter_if #(
  parameter int AW = 10,
  parameter int DW = 32
);
  logic          req;
  logic          we;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic          gnt;
  logic          rvalid;
  logic [DW-1:0] rdata;

  modport master (output req, we, addr, wdata, input gnt, rvalid, rdata);
  modport slave  (input req, we, addr, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/kws_wsram_arbiter.sv
// Round-robin, burst-capped arbiter sharing the single-port weight SRAM between the CNN fetch
// port (m0) and the host port (m1). Define KWS_ARB_STATS_EN for beat/wait counters.
module kws_wsram_arbiter #(
  parameter int AW        = 10,
  parameter int DW        = 32,
  parameter int MAX_BURST = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  kws_wsram_arbiter_if.slave m0,
  kws_wsram_arbiter_if.slave m1,
  output logic               sram_en,
  output logic               sram_we,
  output logic [AW-1:0]      sram_addr,
  output logic [DW-1:0]      sram_wdata,
  input  logic [DW-1:0]      sram_rdata
`ifdef KWS_ARB_STATS_EN
  ,
  input  logic               stat_clr,
  output logic [15:0]        stat_g0,
  output logic [15:0]        stat_g1,
  output logic [15:0]        stat_wait
`endif
);
  localparam int CW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [CW-1:0] CAP = CW'(MAX_BURST - 1);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  state_t        state_reg, state_next;
  logic          last_owner_reg, last_owner_next;
  logic [CW-1:0] beat_cnt_reg, beat_cnt_next;
  logic          gnt0, gnt1;
  logic          sram_en_reg, sram_we_reg, tag_reg;
  logic [AW-1:0] sram_addr_reg;
  logic [DW-1:0] sram_wdata_reg;
  logic [1:0]    rvalid_reg;

  always_comb begin
    state_next      = state_reg;
    last_owner_next = last_owner_reg;
    beat_cnt_next   = beat_cnt_reg;
    gnt0            = 1'b0;
    gnt1            = 1'b0;
    case (state_reg)
      IDLE: begin
        // The IDLE beat is the first beat of the new ownership, so the count starts at 1.
        if (m0.req && (!m1.req || last_owner_reg)) begin
          gnt0          = 1'b1;
          state_next    = OWN0;
          beat_cnt_next = CW'(1);
        end else if (m1.req) begin
          gnt1          = 1'b1;
          state_next    = OWN1;
          beat_cnt_next = CW'(1);
        end
      end
      OWN0: begin
        if (!m0.req) begin
          state_next      = IDLE;
          last_owner_next = 1'b0;
        end else begin
          gnt0 = 1'b1;
          if (beat_cnt_reg == CAP) begin
            beat_cnt_next = '0;
            if (m1.req) begin
              state_next      = OWN1;
              last_owner_next = 1'b0;
            end
          end else begin
            beat_cnt_next = beat_cnt_reg + CW'(1);
          end
        end
      end
      OWN1: begin
        if (!m1.req) begin
          state_next      = IDLE;
          last_owner_next = 1'b1;
        end else begin
          gnt1 = 1'b1;
          if (beat_cnt_reg == CAP) begin
            beat_cnt_next = '0;
            if (m0.req) begin
              state_next      = OWN0;
              last_owner_next = 1'b1;
            end
          end else begin
            beat_cnt_next = beat_cnt_reg + CW'(1);
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      last_owner_reg <= 1'b1;
      beat_cnt_reg   <= '0;
    end else begin
      state_reg      <= state_next;
      last_owner_reg <= last_owner_next;
      beat_cnt_reg   <= beat_cnt_next;
    end
  end

  // tag_reg follows the beat through the SRAM stage so the read returns to its issuer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sram_en_reg    <= 1'b0;
      sram_we_reg    <= 1'b0;
      sram_addr_reg  <= '0;
      sram_wdata_reg <= '0;
      tag_reg        <= 1'b0;
      rvalid_reg     <= '0;
    end else begin
      sram_en_reg    <= gnt0 | gnt1;
      sram_we_reg    <= (gnt0 & m0.we) | (gnt1 & m1.we);
      sram_addr_reg  <= gnt1 ? m1.addr : m0.addr;
      sram_wdata_reg <= gnt1 ? m1.wdata : m0.wdata;
      tag_reg        <= gnt1;
      rvalid_reg[0]  <= sram_en_reg & ~sram_we_reg & ~tag_reg;
      rvalid_reg[1]  <= sram_en_reg & ~sram_we_reg & tag_reg;
    end
  end

  // Grants are masked during reset so every output is quiet while rst_n is low.
  assign m0.gnt     = gnt0 & rst_n;
  assign m1.gnt     = gnt1 & rst_n;
  assign m0.rvalid  = rvalid_reg[0];
  assign m1.rvalid  = rvalid_reg[1];
  assign m0.rdata   = rvalid_reg[0] ? sram_rdata : '0;
  assign m1.rdata   = rvalid_reg[1] ? sram_rdata : '0;
  assign sram_en    = sram_en_reg;
  assign sram_we    = sram_we_reg;
  assign sram_addr  = sram_addr_reg;
  assign sram_wdata = sram_wdata_reg;

`ifdef KWS_ARB_STATS_EN
  logic [2:0] stat_inc;
  assign stat_inc = {(m0.req & ~gnt0) | (m1.req & ~gnt1), gnt1, gnt0};

  for (genvar gi = 0; gi < 3; gi++) begin : g_stat
    logic [15:0] cnt_reg;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_reg <= '0;
      end else if (stat_clr) begin
        cnt_reg <= '0;
      end else if (stat_inc[gi] && cnt_reg != 16'hFFFF) begin
        cnt_reg <= cnt_reg + 16'd1;
      end
    end
  end

  assign stat_g0   = g_stat[0].cnt_reg;
  assign stat_g1   = g_stat[1].cnt_reg;
  assign stat_wait = g_stat[2].cnt_reg;
`endif
endmodule

// File: tb/tb_kws_wsram_arbiter.sv
// Self-checking bench for kws_wsram_arbiter: queue-driven masters, SRAM model, read scoreboard.
module tb_kws_wsram_arbiter;
  localparam int AW = 10;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          sram_en, sram_we;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_wdata;
  logic [DW-1:0] sram_rdata;
`ifdef KWS_ARB_STATS_EN
  logic          stat_clr = 1'b0;
  logic [15:0]   stat_g0, stat_g1, stat_wait;
`endif

  kws_wsram_arbiter_if #(.AW(AW), .DW(DW)) m0_if ();
  kws_wsram_arbiter_if #(.AW(AW), .DW(DW)) m1_if ();

  kws_wsram_arbiter #(.AW(AW), .DW(DW), .MAX_BURST(64)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .m0        (m0_if),
    .m1        (m1_if),
    .sram_en   (sram_en),
    .sram_we   (sram_we),
    .sram_addr (sram_addr),
    .sram_wdata(sram_wdata),
    .sram_rdata(sram_rdata)
`ifdef KWS_ARB_STATS_EN
    ,
    .stat_clr  (stat_clr),
    .stat_g0   (stat_g0),
    .stat_g1   (stat_g1),
    .stat_wait (stat_wait)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {logic we; logic [AW-1:0] addr; logic [DW-1:0] wdata;} beat_t;
  typedef struct {logic [DW-1:0] data; int cyc;} exp_t;

  beat_t         bq0[$], bq1[$];
  exp_t          sb0[$], sb1[$];
  logic [DW-1:0] mem[1024];
  logic [DW-1:0] shadow[1024];
  int            total = 0, bad = 0, cyc = 0;
  logic          acc0 = 1'b0, acc1 = 1'b0;
  logic          prev_acc = 1'b0, prev_we = 1'b0;
  logic [AW-1:0] prev_addr = '0;
  logic [DW-1:0] prev_wdata = '0;

  function automatic logic [DW-1:0] init_word(input int a);
    return (32'(a) * 32'h9E3779B1) ^ 32'h5A5A0000;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // SRAM macro model: one-cycle registered read.
  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = init_word(i);
    sram_rdata = '0;
    forever begin
      @(posedge clk);
      if (sram_en === 1'b1) begin
        if (sram_we) mem[sram_addr] = sram_wdata;
        else sram_rdata <= mem[sram_addr];
      end
    end
  end

  // Master drivers: present the head of each beat queue, retire it once accepted.
  initial begin
    m0_if.req = 1'b0; m0_if.we = 1'b0; m0_if.addr = '0; m0_if.wdata = '0;
    m1_if.req = 1'b0; m1_if.we = 1'b0; m1_if.addr = '0; m1_if.wdata = '0;
    forever begin
      @(posedge clk);
      #1;
      if (acc0 && bq0.size() > 0) bq0.delete(0);
      if (acc1 && bq1.size() > 0) bq1.delete(0);
      if (bq0.size() > 0) begin
        m0_if.req = 1'b1; m0_if.we = bq0[0].we; m0_if.addr = bq0[0].addr; m0_if.wdata = bq0[0].wdata;
      end else m0_if.req = 1'b0;
      if (bq1.size() > 0) begin
        m1_if.req = 1'b1; m1_if.we = bq1[0].we; m1_if.addr = bq1[0].addr; m1_if.wdata = bq1[0].wdata;
      end else m1_if.req = 1'b0;
    end
  end

  // Monitor: grant rules, SRAM control timing, read-return scoreboard.
  initial begin
    exp_t e;
    for (int i = 0; i < 1024; i++) shadow[i] = init_word(i);
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        acc0 = 1'b0; acc1 = 1'b0; prev_acc = 1'b0;
        sb0.delete(); sb1.delete();
        total++;
        if ({sram_en, sram_we, m0_if.gnt, m1_if.gnt, m0_if.rvalid, m1_if.rvalid} !== 6'b0) begin
          bad++;
          $display("FAIL reset_outputs: en=%b we=%b gnt=%b%b rvalid=%b%b, all required 0",
                   sram_en, sram_we, m1_if.gnt, m0_if.gnt, m1_if.rvalid, m0_if.rvalid);
        end
      end else begin
        total++;
        if (m0_if.gnt === 1'b1 && m1_if.gnt === 1'b1) begin
          bad++; $display("FAIL gnt_exclusive: cycle %0d both masters granted", cyc);
        end
        total++;
        if ((m0_if.gnt === 1'b1 && !m0_if.req) || (m1_if.gnt === 1'b1 && !m1_if.req)) begin
          bad++; $display("FAIL gnt_without_req: cycle %0d gnt=%b%b req=%b%b", cyc,
                          m1_if.gnt, m0_if.gnt, m1_if.req, m0_if.req);
        end
        total++;
        if (sram_en !== prev_acc || (prev_acc && (sram_we !== prev_we || sram_addr !== prev_addr ||
            (prev_we && sram_wdata !== prev_wdata)))) begin
          bad++;
          $display("FAIL sram_ctrl: cycle %0d en=%b we=%b addr=%h got, required en=%b we=%b addr=%h",
                   cyc, sram_en, sram_we, sram_addr, prev_acc, prev_we, prev_addr);
        end
        if (m0_if.rvalid === 1'b1) begin
          total++;
          if (sb0.size() == 0) begin
            bad++; $display("FAIL m0_rvalid_unexpected: cycle %0d rdata=%h, no read outstanding", cyc, m0_if.rdata);
          end else begin
            e = sb0.pop_front();
            if (m0_if.rdata !== e.data || cyc !== e.cyc) begin
              bad++; $display("FAIL m0_read: rdata=%h at cycle %0d, required %h at cycle %0d",
                              m0_if.rdata, cyc, e.data, e.cyc);
            end
          end
        end else begin
          total++;
          if (m0_if.rdata !== '0) begin
            bad++; $display("FAIL m0_rdata_gate: rdata=%h with rvalid low, required 0", m0_if.rdata);
          end
          if (sb0.size() > 0 && sb0[0].cyc <= cyc) begin
            total++; bad++;
            $display("FAIL m0_rvalid_missing: cycle %0d rvalid=0, required 1 (data %h)", cyc, sb0[0].data);
            e = sb0.pop_front();
          end
        end
        if (m1_if.rvalid === 1'b1) begin
          total++;
          if (sb1.size() == 0) begin
            bad++; $display("FAIL m1_rvalid_unexpected: cycle %0d rdata=%h, no read outstanding", cyc, m1_if.rdata);
          end else begin
            e = sb1.pop_front();
            if (m1_if.rdata !== e.data || cyc !== e.cyc) begin
              bad++; $display("FAIL m1_read: rdata=%h at cycle %0d, required %h at cycle %0d",
                              m1_if.rdata, cyc, e.data, e.cyc);
            end
          end
        end else begin
          total++;
          if (m1_if.rdata !== '0) begin
            bad++; $display("FAIL m1_rdata_gate: rdata=%h with rvalid low, required 0", m1_if.rdata);
          end
          if (sb1.size() > 0 && sb1[0].cyc <= cyc) begin
            total++; bad++;
            $display("FAIL m1_rvalid_missing: cycle %0d rvalid=0, required 1 (data %h)", cyc, sb1[0].data);
            e = sb1.pop_front();
          end
        end
        acc0 = m0_if.req && (m0_if.gnt === 1'b1);
        acc1 = m1_if.req && (m1_if.gnt === 1'b1);
        if (acc0) begin
          if (m0_if.we) shadow[m0_if.addr] = m0_if.wdata;
          else sb0.push_back(exp_t'{shadow[m0_if.addr], cyc + 2});
        end
        if (acc1) begin
          if (m1_if.we) shadow[m1_if.addr] = m1_if.wdata;
          else sb1.push_back(exp_t'{shadow[m1_if.addr], cyc + 2});
        end
        prev_acc   = acc0 | acc1;
        prev_we    = acc1 ? m1_if.we : m0_if.we;
        prev_addr  = acc1 ? m1_if.addr : m0_if.addr;
        prev_wdata = acc1 ? m1_if.wdata : m0_if.wdata;
      end
    end
  end

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (bq0.size() == 0 && bq1.size() == 0 && !m0_if.req && !m1_if.req &&
          sb0.size() == 0 && sb1.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    bit ok;
    bq0.push_back(beat_t'{1'b0, AW'(5), '0});
    repeat (3) begin
      @(negedge clk);
      total++;
      if (sram_en !== 1'b0 || sram_we !== 1'b0 || sram_addr !== '0 || sram_wdata !== '0 ||
          m0_if.gnt !== 1'b0 || m1_if.gnt !== 1'b0 || m0_if.rvalid !== 1'b0 || m0_if.rdata !== '0) begin
        bad++;
        $display("FAIL test_reset: en=%b addr=%h gnt0=%b rvalid0=%b rdata0=%h, all required 0",
                 sram_en, sram_addr, m0_if.gnt, m0_if.rvalid, m0_if.rdata);
      end
    end
    @(posedge clk); #2; rst_n = 1'b1;
    wait_idle(ok);
    total++;
    if (!ok) begin bad++; $display("FAIL test_reset_drain: ok=%b required 1", ok); end
    $display("test_reset complete");
  endtask

  task automatic test_m0_burst();
    int n = 0;
    bit m1_seen = 1'b0;
    bit ok;
    for (int a = 0; a < 240; a++) bq0.push_back(beat_t'{1'b0, AW'(a), '0});
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (m0_if.req) begin
        total++;
        if (m0_if.gnt !== 1'b1) begin
          bad++; $display("FAIL m0_burst_gnt: beat cycle %0d gnt=%b required 1", i, m0_if.gnt);
        end
      end
      if (m0_if.gnt === 1'b1) n++;
      if (m1_if.gnt === 1'b1) m1_seen = 1'b1;
      if (bq0.size() == 0 && !m0_if.req) break;
    end
    total++;
    if (n !== 240) begin bad++; $display("FAIL m0_burst_count: grants=%0d required 240", n); end
    total++;
    if (m1_seen !== 1'b0) begin bad++; $display("FAIL m0_burst_m1: m1 granted=%b required 0", m1_seen); end
    wait_idle(ok);
    total++;
    if (!ok) begin bad++; $display("FAIL m0_burst_drain: ok=%b required 1", ok); end
    $display("test_m0_burst complete: %0d grants", n);
  endtask

  task automatic test_contention();
    int who, exp_who;
    bit ok;
    @(posedge clk); #2; rst_n = 1'b0;
    for (int a = 0; a < 70; a++) begin
      bq0.push_back(beat_t'{1'b0, AW'(100 + a), '0});
      bq1.push_back(beat_t'{1'b0, AW'(600 + a), '0});
    end
    @(posedge clk); #2; rst_n = 1'b1;
    for (int idx = 0; idx <= 128; idx++) begin
      @(negedge clk);
      exp_who = (idx < 64 || idx == 128) ? 0 : 1;
      who = (m0_if.gnt === 1'b1) ? 0 : ((m1_if.gnt === 1'b1) ? 1 : 2);
      total++;
      if (who !== exp_who) begin
        bad++; $display("FAIL contention_owner: cycle %0d owner=%0d required %0d", idx, who, exp_who);
      end
      if (idx == 65) begin
        total++;
        if (m0_if.rvalid !== 1'b1 || m1_if.rvalid !== 1'b0) begin
          bad++; $display("FAIL switch_rvalid: rvalid0=%b rvalid1=%b, required 1 0", m0_if.rvalid, m1_if.rvalid);
        end
      end
      if (idx == 66) begin
        total++;
        if (m0_if.rvalid !== 1'b0 || m1_if.rvalid !== 1'b1) begin
          bad++; $display("FAIL switch_rvalid_next: rvalid0=%b rvalid1=%b, required 0 1", m0_if.rvalid, m1_if.rvalid);
        end
      end
    end
    wait_idle(ok);
    total++;
    if (!ok) begin bad++; $display("FAIL contention_drain: ok=%b required 1", ok); end
    $display("test_contention complete");
  endtask

  task automatic test_write_read();
    bit ok, seen;
    logic [DW-1:0] got;
    bq1.push_back(beat_t'{1'b1, AW'(10'h3FF), 32'hDEADBEEF});
    wait_idle(ok);
    bq0.push_back(beat_t'{1'b0, AW'(10'h3FF), '0});
    seen = 1'b0;
    got  = '0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (m0_if.rvalid === 1'b1) begin seen = 1'b1; got = m0_if.rdata; break; end
    end
    total++;
    if (!seen || got !== 32'hDEADBEEF) begin
      bad++; $display("FAIL write_read: seen=%b rdata=%h required DEADBEEF", seen, got);
    end
    wait_idle(ok);
    total++;
    if (!ok) begin bad++; $display("FAIL write_read_drain: ok=%b required 1", ok); end
    $display("test_write_read complete: rdata=%h", got);
  endtask

  task automatic test_reset_inflight();
    bit ok, seen;
    bq0.push_back(beat_t'{1'b0, AW'(7), '0});
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (m0_if.gnt === 1'b1) begin seen = 1'b1; break; end
    end
    total++;
    if (!seen) begin bad++; $display("FAIL inflight_gnt: granted=%b required 1", seen); end
    @(posedge clk); #2;
    total++;
    if (sram_en !== 1'b1) begin bad++; $display("FAIL inflight_en: sram_en=%b required 1", sram_en); end
    rst_n = 1'b0;
    repeat (2) begin
      @(negedge clk);
      total++;
      if (sram_en !== 1'b0 || m0_if.rvalid !== 1'b0) begin
        bad++; $display("FAIL inflight_reset: sram_en=%b rvalid0=%b required 0 0", sram_en, m0_if.rvalid);
      end
    end
    @(posedge clk); #2; rst_n = 1'b1;
    bq0.push_back(beat_t'{1'b0, AW'(8), '0});
    bq1.push_back(beat_t'{1'b0, AW'(9), '0});
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (m0_if.req || m1_if.req) begin seen = 1'b1; break; end
    end
    total++;
    if (!seen || m0_if.gnt !== 1'b1 || m1_if.gnt !== 1'b0) begin
      bad++; $display("FAIL reset_tiebreak: gnt0=%b gnt1=%b required 1 0", m0_if.gnt, m1_if.gnt);
    end
    wait_idle(ok);
    total++;
    if (!ok) begin bad++; $display("FAIL inflight_drain: ok=%b required 1", ok); end
    $display("test_reset_inflight complete");
  endtask

`ifdef KWS_ARB_STATS_EN
  task automatic test_stats();
    bit ok;
    @(posedge clk); #2; rst_n = 1'b0;
    for (int a = 0; a < 100; a++) bq0.push_back(beat_t'{1'b0, AW'(a), '0});
    for (int a = 0; a < 10; a++) bq1.push_back(beat_t'{1'b0, AW'(300 + a), '0});
    @(negedge clk);
    total++;
    if (stat_g0 !== 16'd0 || stat_g1 !== 16'd0 || stat_wait !== 16'd0) begin
      bad++; $display("FAIL stats_reset: g0=%0d g1=%0d wait=%0d required 0", stat_g0, stat_g1, stat_wait);
    end
    @(posedge clk); #2; rst_n = 1'b1;
    wait_idle(ok);
    total++;
    if (!ok) begin bad++; $display("FAIL stats_drain: ok=%b required 1", ok); end
    total++;
    if (stat_g0 !== 16'd100) begin bad++; $display("FAIL stat_g0: %0d required 100", stat_g0); end
    total++;
    if (stat_g1 !== 16'd10) begin bad++; $display("FAIL stat_g1: %0d required 10", stat_g1); end
    total++;
    if (stat_wait !== 16'd75) begin bad++; $display("FAIL stat_wait: %0d required 75", stat_wait); end
    @(posedge clk); #2; stat_clr = 1'b1;
    @(posedge clk); #2; stat_clr = 1'b0;
    @(negedge clk);
    total++;
    if (stat_g0 !== 16'd0 || stat_g1 !== 16'd0 || stat_wait !== 16'd0) begin
      bad++; $display("FAIL stat_clr: g0=%0d g1=%0d wait=%0d required 0", stat_g0, stat_g1, stat_wait);
    end
    $display("test_stats complete");
  endtask
`endif

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_m0_burst();
    test_contention();
    test_write_read();
    test_reset_inflight();
`ifdef KWS_ARB_STATS_EN
    test_stats();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
